// File: rtl/build_info_pkg.sv
// Shared types for the build-info LED readout: word select, controller state,
// and the nibble count that each kind of build-info word has.
package build_info_pkg;

    typedef enum logic [1:0] {
        SEL_GH_SCRIPTS = 2'd0,
        SEL_GH_TOP     = 2'd1,
        SEL_TS_SCRIPTS = 2'd2,
        SEL_TS_TOP     = 2'd3
    } sel_e;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SHOW   = 3'd3,
        ST_GAP    = 3'd4,
        ST_FINISH = 3'd5
    } state_e;

    localparam logic [4:0] NIB_CNT_64 = 5'd16;
    localparam logic [4:0] NIB_CNT_32 = 5'd8;

    // Git hashes are 64-bit words, timestamps are 32-bit words.
    function automatic logic [4:0] nib_count(input sel_e sel);
        return (sel == SEL_GH_SCRIPTS || sel == SEL_GH_TOP) ? NIB_CNT_64 : NIB_CNT_32;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Down-counter shared by the nibble dwell and the inter-nibble gap; it fires
// expire for the single cycle in which an armed count has reached zero.
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;
    logic         armed;

    // Disarming at zero keeps the count from wrapping and the expire single-cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= load_val;
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == '0) armed <= 1'b0;
            else           cnt   <= cnt - 1'b1;
        end
    end

    assign expire = armed && (cnt == '0);

endmodule

// File: rtl/build_info_led_seq.sv
// Blinks one build-info word out through the LED counter, one divider per
// nibble (MSB first), separated by idle-rate gaps.
module build_info_led_seq
    import build_info_pkg::*;
#(
    parameter int DIV_W     = 5,
    parameter int DWELL_CYC = 100_000_000,
    parameter int GAP_CYC   = 50_000_000,
    parameter int DIV_BASE  = 4,
    parameter int IDLE_DIV  = 24
) (
    input  logic             clk100,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [1:0]       sel_i,
    input  logic [63:0]      git_hash_scripts_i,
    input  logic [63:0]      git_hash_top_i,
    input  logic [31:0]      timestamp_scripts_i,
    input  logic [31:0]      timestamp_top_i,
    output logic [DIV_W-1:0] div_o,
    output logic             wren_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       nib_idx_o
);

    localparam int MAX_CYC = (DWELL_CYC > GAP_CYC) ? DWELL_CYC : GAP_CYC;
    localparam int TMR_W   = $clog2(MAX_CYC);
    // The gap load is two short because the LOAD cycle adds one before the write.
    localparam logic [TMR_W-1:0] SHOW_LOAD = TMR_W'(DWELL_CYC - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYC - 2);
    localparam logic [DIV_W-1:0] IDLE_VAL  = DIV_W'(IDLE_DIV);
    localparam logic [DIV_W-1:0] BASE_VAL  = DIV_W'(DIV_BASE);

    state_e             state, state_n;
    logic [63:0]        shreg;
    logic [63:0]        sel_word;
    logic [4:0]         nib_cnt;
    logic               abort_pend;
    logic               tmr_load, tmr_expire;
    logic [TMR_W-1:0]   tmr_val;
    logic [DIV_W-1:0]   div_n;
    logic               wren_n, done_n, busy_n, pend_n;
    logic               latch, shift;
    logic               last_nib, abort_req, abort_now;

    assign last_nib  = ({1'b0, nib_idx_o} == (nib_cnt - 5'd1));
    assign abort_req = abort_i | abort_pend;
    // An abort seen while a write is on the bus is held one cycle so strobes never abut.
    assign abort_now = abort_req & ~wren_o;

    always_comb begin
        case (sel_e'(sel_i))
            SEL_GH_SCRIPTS: sel_word = git_hash_scripts_i;
            SEL_GH_TOP:     sel_word = git_hash_top_i;
            SEL_TS_SCRIPTS: sel_word = {timestamp_scripts_i, 32'h0};
            default:        sel_word = {timestamp_top_i, 32'h0};
        endcase
    end

    dwell_timer #(.W(TMR_W)) u_timer (
        .clk      (clk100),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) state <= ST_INIT;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_INIT:   state_n = ST_IDLE;
            ST_IDLE:   if (start_i && !abort_i) state_n = ST_LOAD;
            ST_LOAD:   state_n = abort_now ? ST_FINISH : ST_SHOW;
            ST_SHOW: begin
                if (abort_now)       state_n = ST_FINISH;
                else if (tmr_expire) state_n = last_nib ? ST_FINISH : ST_GAP;
            end
            ST_GAP: begin
                if (abort_now)       state_n = ST_FINISH;
                else if (tmr_expire) state_n = ST_LOAD;
            end
            ST_FINISH: state_n = ST_IDLE;
            default:   state_n = ST_INIT;
        endcase
    end

    // Next values of the registered outputs; every write is decided one edge early.
    always_comb begin
        div_n    = div_o;
        wren_n   = 1'b0;
        done_n   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = '0;
        latch    = 1'b0;
        shift    = 1'b0;
        case (state)
            ST_INIT: begin
                wren_n = 1'b1;
                div_n  = IDLE_VAL;
            end
            ST_IDLE: latch = start_i && !abort_i;
            ST_LOAD: begin
                wren_n = 1'b1;
                if (abort_now) begin
                    div_n  = IDLE_VAL;
                    done_n = 1'b1;
                end else begin
                    div_n    = BASE_VAL + DIV_W'(shreg[63:60]);
                    tmr_load = 1'b1;
                    tmr_val  = SHOW_LOAD;
                end
            end
            ST_SHOW: begin
                if (abort_now || (tmr_expire && last_nib)) begin
                    wren_n = 1'b1;
                    div_n  = IDLE_VAL;
                    done_n = 1'b1;
                end else if (tmr_expire) begin
                    wren_n   = 1'b1;
                    div_n    = IDLE_VAL;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (abort_now) begin
                    wren_n = 1'b1;
                    div_n  = IDLE_VAL;
                    done_n = 1'b1;
                end else if (tmr_expire) begin
                    shift = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy_n = state_n inside {ST_LOAD, ST_SHOW, ST_GAP, ST_FINISH};
    assign pend_n = (state inside {ST_LOAD, ST_SHOW, ST_GAP}) && abort_req && wren_o;

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            div_o      <= IDLE_VAL;
            wren_o     <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            nib_idx_o  <= 4'd0;
            shreg      <= '0;
            nib_cnt    <= NIB_CNT_64;
            abort_pend <= 1'b0;
        end else begin
            div_o      <= div_n;
            wren_o     <= wren_n;
            busy_o     <= busy_n;
            done_o     <= done_n;
            abort_pend <= pend_n;
            if (latch) begin
                shreg     <= sel_word;
                nib_cnt   <= nib_count(sel_e'(sel_i));
                nib_idx_o <= 4'd0;
            end else if (shift) begin
                shreg     <= {shreg[59:0], 4'h0};
                nib_idx_o <= nib_idx_o + 4'd1;
            end
        end
    end

endmodule
